// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: pops one sample per run, shifts it into a circular delay line and
// walks TAPS coefficient/sample pairs through a signed MAC. Define FIR_SAT_EN to saturate the accumulator.
module fir_tap_sequencer #(
  parameter int TAPS   = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [15:0]       fifo_rd_data,
  input  logic              cload,
  input  logic [ADDR_W-1:0] caddr,
  input  logic [15:0]       cin,
  output logic [31:0]       y,
  output logic              y_valid,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POP  = 3'd1,
    S_CAPT = 3'd2,
    S_MAC  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]         k_q, k_d;
  logic signed [31:0]        acc_q, acc_d;
  logic [31:0]               y_q, y_d;
  logic                      y_valid_q, y_valid_d;
  logic                      rd_en_q, rd_en_d;
  logic                      busy_q, busy_d;
  logic signed [15:0]        coef_q  [TAPS];
  logic signed [15:0]        xline_q [TAPS];

  logic                      coef_we_s;
  logic                      xline_we_s;
  logic [ADDR_W-1:0]         rd_idx_s;
  logic signed [15:0]        coef_sel_s;
  logic signed [15:0]        x_sel_s;
  logic signed [31:0]        coef_ext_s;
  logic signed [31:0]        x_ext_s;
  logic signed [31:0]        prod_s;

  // Two's-complement add; with FIR_SAT_EN the result clamps to the signed 32-bit range.
  function automatic logic signed [31:0] mac_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
    logic [32:0] sum;
    sum = {a[31], a} + {b[31], b};
`ifdef FIR_SAT_EN
    if (sum[32] != sum[31]) begin
      mac_add = sum[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end else begin
      mac_add = sum[31:0];
    end
`else
    mac_add = sum[31:0];
`endif
  endfunction

  // Newest sample sits at wr_ptr; tap k looks k entries back, wrapping naturally in ADDR_W bits.
  assign rd_idx_s   = wr_ptr_q - k_q;
  assign coef_sel_s = coef_q[k_q];
  assign x_sel_s    = xline_q[rd_idx_s];
  assign coef_ext_s = {{16{coef_sel_s[15]}}, coef_sel_s};
  assign x_ext_s    = {{16{x_sel_s[15]}}, x_sel_s};
  assign prod_s     = coef_ext_s * x_ext_s;

  // Next-state, datapath update and registered-output decode.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    k_d        = k_q;
    acc_d      = acc_q;
    coef_we_s  = 1'b0;
    xline_we_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cload) begin
          coef_we_s = 1'b1;
        end else if (!fifo_empty) begin
          state_d = S_POP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POP: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        xline_we_s = 1'b1;
        acc_d      = 32'sd0;
        k_d        = {ADDR_W{1'b0}};
        state_d    = S_MAC;
      end
      S_MAC: begin
        acc_d = mac_add(acc_q, prod_s);
        k_d   = k_q + ADDR_W'(1);
        if (k_q == ADDR_W'(TAPS - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MAC;
        end
      end
      S_DONE: begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with the state they describe.
    rd_en_d   = (state_d == S_POP);
    busy_d    = (state_d != S_IDLE);
    y_valid_d = (state_d == S_DONE);
    if (state_d == S_DONE) begin
      y_d = acc_d;
    end else begin
      y_d = y_q;
    end
  end

  // Control state, accumulator and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= {ADDR_W{1'b0}};
      k_q       <= {ADDR_W{1'b0}};
      acc_q     <= 32'sd0;
      y_q       <= 32'd0;
      y_valid_q <= 1'b0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
    end
  end

  // Coefficient file and delay line; both clear on reset so startup history reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i]  <= 16'sd0;
        xline_q[i] <= 16'sd0;
      end
    end else begin
      if (coef_we_s) begin
        coef_q[caddr] <= cin;
      end
      if (xline_we_s) begin
        xline_q[wr_ptr_q] <= fifo_rd_data;
      end
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign busy       = busy_q;
  assign y_valid    = y_valid_q;
  assign y          = y_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: FIFO model, coefficient loading and hand-computed outputs.
module tb_fir_tap_sequencer;
  localparam int TAPS = 64;

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data = 16'd0;
  logic        cload = 1'b0;
  logic [5:0]  caddr = 6'd0;
  logic [15:0] cin = 16'd0;
  logic [31:0] y;
  logic        y_valid;
  logic        busy;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          last_rd_cyc = -1;
  int          rd_cnt = 0;
  int          off_cyc;
  int          t;
  bit          seen_rd = 1'b0;
  bit          seen_busy = 1'b0;
  logic [15:0] fifo_q[$];
  logic [31:0] outs[$];
  int          lat[$];
  logic [31:0] exp_v;

  fir_tap_sequencer #(.TAPS(TAPS), .ADDR_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .cload        (cload),
    .caddr        (caddr),
    .cin          (cin),
    .y            (y),
    .y_valid      (y_valid),
    .busy         (busy)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, $signed(got), got, $signed(expv), expv);
    end
  endtask

  // One cycle: sample outputs on the falling edge and run the FIFO read-side model.
  task automatic tick();
    bit dec_empty;
    dec_empty = fifo_empty;
    @(negedge clk);
    cyc++;
    if (fifo_rd_en) begin
      rd_cnt++;
      seen_rd     = 1'b1;
      last_rd_cyc = cyc;
      check_eq("rd_gate", {31'd0, dec_empty}, 32'd0);
      if (fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
    end
    if (busy) seen_busy = 1'b1;
    if (y_valid) begin
      outs.push_back(y);
      lat.push_back(cyc - last_rd_cyc);
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [15:0] v);
    fifo_q.push_back(v);
    fifo_empty = 1'b0;
  endtask

  task automatic load_coef(input int a, input logic [15:0] v);
    cload = 1'b1;
    caddr = a[5:0];
    cin   = v;
    tick();
    cload = 1'b0;
  endtask

  task automatic wait_outs(input int n, input int budget);
    int k;
    k = 0;
    while (outs.size() < n && k < budget) begin
      tick();
      k++;
    end
    check_eq("outs_count", outs.size(), n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    fifo_q.delete();
    outs.delete();
    lat.delete();
    rd_cnt = 0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Asynchronous reset with the clock stopped
    #2 rst = 1'b1;
    #1;
    check_eq("rst_y", y, 32'd0);
    check_eq("rst_y_valid", {31'd0, y_valid}, 32'd0);
    check_eq("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    clk_run = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Delta coefficient
    load_coef(0, 16'd1);
    push(16'd5);
    push(-16'sd7);
    wait_outs(2, 400);
    check_eq("delta_y0", outs[0], 32'd5);
    check_eq("delta_y1", outs[1], -32'sd7);
    check_eq("delta_lat0", lat[0], 32'd66);
    check_eq("delta_lat1", lat[1], 32'd66);
    check_eq("delta_rd_cnt", rd_cnt, 32'd2);
    repeat (10) tick();
    check_eq("y_hold", y, -32'sd7);
    check_eq("y_valid_low", {31'd0, y_valid}, 32'd0);

    // Impulse response with coef[k] = k+1
    do_reset();
    for (int k = 0; k < TAPS; k++) load_coef(k, 16'(k + 1));
    push(16'd1);
    for (int k = 1; k < TAPS; k++) push(16'd0);
    wait_outs(TAPS, TAPS * 70 + 50);
    for (int k = 0; k < TAPS; k++) check_eq($sformatf("impulse_%0d", k), outs[k], 32'(k + 1));
    check_eq("impulse_lat_last", lat[TAPS-1], 32'd66);
    check_eq("impulse_rd_cnt", rd_cnt, 32'(TAPS));

    // Empty gating, then cload priority over a pending pop
    do_reset();
    seen_rd   = 1'b0;
    seen_busy = 1'b0;
    repeat (200) tick();
    check_eq("empty_no_rd", {31'd0, seen_rd}, 32'd0);
    check_eq("empty_no_busy", {31'd0, seen_busy}, 32'd0);
    push(16'd4);
    cload = 1'b1; caddr = 6'd0; cin = 16'd3;
    tick();
    caddr = 6'd1; cin = 16'd100;
    tick();
    caddr = 6'd2; cin = 16'd1000;
    tick();
    cload = 1'b0;
    check_eq("cload_blocks_pop", {31'd0, seen_rd}, 32'd0);
    off_cyc     = cyc;
    last_rd_cyc = -1;
    wait_outs(1, 200);
    check_eq("pop_after_cload", 32'(last_rd_cyc), 32'(off_cyc + 1));
    check_eq("cload_y0", outs[0], 32'd12);
    push(16'd2);
    repeat (5) tick();
    cload = 1'b1; caddr = 6'd0; cin = 16'd77;
    repeat (10) tick();
    cload = 1'b0;
    wait_outs(2, 200);
    check_eq("taps_y1", outs[1], 32'd406);
    push(16'd1);
    wait_outs(3, 200);
    check_eq("cload_ignored_busy", outs[2], 32'd4203);

    // Overflow: all coefficients and samples at full scale
    do_reset();
    for (int k = 0; k < TAPS; k++) load_coef(k, 16'd32767);
    for (int k = 0; k < TAPS; k++) push(16'd32767);
    wait_outs(TAPS, TAPS * 70 + 50);
    check_eq("ovf_y2", outs[1], 32'd2147352578);
`ifdef FIR_SAT_EN
    exp_v = 32'h7FFF_FFFF;
`else
    exp_v = -32'sd1073938429;
`endif
    check_eq("ovf_y3", outs[2], exp_v);
`ifdef FIR_SAT_EN
    exp_v = 32'h7FFF_FFFF;
`else
    exp_v = -32'sd4194240;
`endif
    check_eq("ovf_y64", outs[TAPS-1], exp_v);

    // Reset in the middle of a MAC run
    outs.delete();
    last_rd_cyc = -1;
    push(16'd100);
    t = 0;
    while (last_rd_cyc < 0 && t < 50) begin
      tick();
      t++;
    end
    check_eq("midmac_pop_seen", {31'd0, last_rd_cyc >= 0}, 32'd1);
    repeat (20) tick();
    rst = 1'b1;
    #1;
    check_eq("midmac_rst_y", y, 32'd0);
    check_eq("midmac_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    outs.delete();
    repeat (100) tick();
    check_eq("midmac_no_valid", outs.size(), 32'd0);
    check_eq("midmac_y_zero", y, 32'd0);
    load_coef(0, 16'd1);
    load_coef(1, 16'd1);
    push(16'd9);
    wait_outs(1, 200);
    check_eq("midmac_clean_y", outs[0], 32'd9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
